// File: rtl/mem_port_sched_pkg.sv
// Shared state encoding, width decode and address constants for the memory port scheduler.
package mem_port_sched_pkg;

   localparam int unsigned ADDR_W_DEF = 32;

   // Bits [17:16] of an address select the UART window when equal to this value.
   localparam logic [1:0] IO_ADDR_SEL = 2'b11;

   localparam logic [2:0] WIDTH_B1 = 3'd1;
   localparam logic [2:0] WIDTH_B2 = 3'd2;
   localparam logic [2:0] WIDTH_B4 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   function automatic logic [2:0] decode_width(input logic [2:0] width);
      logic [2:0] nbytes;
      case (width)
         WIDTH_B1: nbytes = WIDTH_B1;
         WIDTH_B2: nbytes = WIDTH_B2;
         default:  nbytes = WIDTH_B4;
      endcase
      return nbytes;
   endfunction

endpackage

// File: rtl/mem_port_sched_byte_seq.sv
// mem_byte_sequencer: walks the bytes of one access, drives the RAM pins,
// assembles read data little-endian and holds UART writes while the TX buffer is full.
module mem_byte_sequencer
   import mem_port_sched_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy_i,
   input  logic              start_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [2:0]        nbytes_i,
   input  logic [31:0]       wdata_i,
   input  logic              run_i,
   input  logic              io_full_i,
   input  logic [7:0]        mem_din_i,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic [7:0]        mem_dout_o,
   output logic              mem_wr_o,
   output logic              last_o,
   output logic [31:0]       word_o
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [2:0]        iss_q, iss_d;
   logic [2:0]        cap_q, cap_d;
   logic [2:0]        nb_q, nb_d;
   logic              pend_q, pend_d;
   logic              wr_q, wr_d;
   logic              stall_s, issue_s, capture_s;
   logic [31:0]       word_s;

   // Issue/capture decode and pin drive for the current cycle.
   always_comb begin
      stall_s   = wr_q && (addr_q[17:16] == IO_ADDR_SEL) && io_full_i;
      issue_s   = run_i && rdy_i && (iss_q < nb_q) && !stall_s;
      capture_s = run_i && rdy_i && !wr_q && pend_q;
      word_s    = data_q;
      if (capture_s) begin
         word_s[{cap_q[1:0], 3'b000} +: 8] = mem_din_i;
      end else begin
         word_s = data_q;
      end
      if (wr_q) begin
         last_o = issue_s && (iss_q == nb_q - 3'd1);
      end else begin
         last_o = capture_s && (cap_q == nb_q - 3'd1);
      end
      mem_wr_o   = wr_q && issue_s;
      mem_dout_o = data_q[7:0];
      // While paused, keep presenting the address whose data is still owed so it is valid on resume.
      if (run_i && !rdy_i && pend_q) begin
         mem_a_o = addr_q - ADDR_ONE;
      end else begin
         mem_a_o = addr_q;
      end
   end

   assign word_o = word_s;

   // Byte counters, address and data next state.
   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      iss_d  = iss_q;
      cap_d  = cap_q;
      nb_d   = nb_q;
      pend_d = pend_q;
      wr_d   = wr_q;
      if (start_i) begin
         addr_d = base_i;
         nb_d   = nbytes_i;
         wr_d   = write_i;
         iss_d  = 3'd0;
         cap_d  = 3'd0;
         pend_d = 1'b0;
         data_d = write_i ? wdata_i : 32'd0;
      end else if (run_i && rdy_i) begin
         pend_d = issue_s && !wr_q;
         if (issue_s) begin
            addr_d = addr_q + ADDR_ONE;
            iss_d  = iss_q + 3'd1;
         end else begin
            addr_d = addr_q;
            iss_d  = iss_q;
         end
         if (wr_q) begin
            data_d = issue_s ? {8'd0, data_q[31:8]} : data_q;
            cap_d  = cap_q;
         end else begin
            data_d = word_s;
            cap_d  = capture_s ? cap_q + 3'd1 : cap_q;
         end
      end else begin
         pend_d = pend_q;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         data_q <= 32'd0;
         iss_q  <= 3'd0;
         cap_q  <= 3'd0;
         nb_q   <= 3'd0;
         pend_q <= 1'b0;
         wr_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         iss_q  <= iss_d;
         cap_q  <= cap_d;
         nb_q   <= nb_d;
         pend_q <= pend_d;
         wr_q   <= wr_d;
      end
   end

endmodule

// File: rtl/mem_port_sched.sv
// Byte-serial scheduler sharing the 8-bit RAM/UART port between fetch and the LSB.
// Optional fetch anti-starvation: define MEM_SCHED_FAIR_EN.
module mem_port_sched
   import mem_port_sched_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned STARVE_LIMIT = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ok,
   output logic [31:0]       if_data,
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [2:0]        lsb_width,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_wdata,
   output logic              lsb_ok,
   output logic [31:0]       lsb_rdata,
   input  logic              flush,
   output logic              busy
);

   sched_state_e      state_q, state_d;
   logic              client_if_q, client_if_d;
   logic              we_q, we_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       lsb_rdata_q, lsb_rdata_d;
   logic              grant_lsb_s, grant_if_s, start_s, run_s, last_s, seq_wr_s;
   logic [ADDR_W-1:0] base_s;
   logic [2:0]        nb_s;
   logic [31:0]       word_s;

`ifdef MEM_SCHED_FAIR_EN
   localparam int unsigned        CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             force_if_s;

   // Fetch wins once the LSB has taken STARVE_LIMIT grants back to back over a waiting fetch.
   always_comb begin
      force_if_s  = (starve_q >= CNT_MAX) && if_req && !flush;
      grant_lsb_s = lsb_req && !force_if_s;
   end

   // Starvation counter next state.
   always_comb begin
      starve_d = starve_q;
      if (start_s && grant_if_s) begin
         starve_d = '0;
      end else if (start_s && if_req) begin
         starve_d = (starve_q < CNT_MAX) ? starve_q + CNT_ONE : starve_q;
      end else if (start_s) begin
         starve_d = '0;
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   // Strict LSB priority.
   always_comb begin
      grant_lsb_s = lsb_req;
   end
`endif

   // A flush cancels any fetch win in the same cycle.
   always_comb begin
      grant_if_s = !grant_lsb_s && if_req && !flush;
      if (grant_lsb_s) begin
         base_s   = lsb_addr;
         nb_s     = decode_width(lsb_width);
         seq_wr_s = lsb_we;
      end else begin
         base_s   = if_addr;
         nb_s     = WIDTH_B4;
         seq_wr_s = 1'b0;
      end
   end

   // Transaction FSM next state and result capture.
   always_comb begin
      state_d     = state_q;
      client_if_d = client_if_q;
      we_d        = we_q;
      if_data_d   = if_data_q;
      lsb_rdata_d = lsb_rdata_q;
      start_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rdy && (grant_lsb_s || grant_if_s)) begin
               start_s     = 1'b1;
               client_if_d = grant_if_s;
               we_d        = seq_wr_s;
               state_d     = seq_wr_s ? ST_WRITE : ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (!rdy) begin
               state_d = ST_READ;
            end else if (flush) begin
               state_d = ST_IDLE;
            end else if (last_s) begin
               state_d = ST_DONE;
               if (client_if_q) begin
                  if_data_d = word_s;
               end else begin
                  lsb_rdata_d = word_s;
               end
            end else begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (rdy && last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE: begin
            if (rdy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         client_if_q <= 1'b0;
         we_q        <= 1'b0;
         if_data_q   <= 32'd0;
         lsb_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         client_if_q <= client_if_d;
         we_q        <= we_d;
         if_data_q   <= if_data_d;
         lsb_rdata_q <= lsb_rdata_d;
      end
   end

   assign run_s = (state_q == ST_READ) || (state_q == ST_WRITE);

   mem_byte_sequencer #(
      .ADDR_W (ADDR_W)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .rdy_i      (rdy),
      .start_i    (start_s),
      .write_i    (seq_wr_s),
      .base_i     (base_s),
      .nbytes_i   (nb_s),
      .wdata_i    (lsb_wdata),
      .run_i      (run_s),
      .io_full_i  (io_buffer_full),
      .mem_din_i  (mem_din),
      .mem_a_o    (mem_a),
      .mem_dout_o (mem_dout),
      .mem_wr_o   (mem_wr),
      .last_o     (last_s),
      .word_o     (word_s)
   );

   // Read completions are suppressed in any flush cycle; store completions never are.
   assign if_ok     = (state_q == ST_DONE) && client_if_q && rdy && !flush;
   assign lsb_ok    = (state_q == ST_DONE) && !client_if_q && rdy && !(flush && !we_q);
   assign if_data   = if_data_q;
   assign lsb_rdata = lsb_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed self-checking bench for mem_port_sched with a one-cycle-latency RAM model.
module tb_mem_port_sched;

   logic        clk = 1'b0;
   logic        rst, rdy, io_buffer_full, flush;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req, if_ok;
   logic [31:0] if_addr, if_data;
   logic        lsb_req, lsb_we, lsb_ok;
   logic [2:0]  lsb_width;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic        busy;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          if_ok_cnt = 0;
   int          okc, wn;
   logic [7:0]  ram [logic [31:0]];
   logic [31:0] wl_a [$];
   logic [7:0]  wl_d [$];
   bit          gnt [$];
   logic [31:0] w;

   mem_port_sched #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
      .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
      .lsb_wdata(lsb_wdata), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
      .flush(flush), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM: data for the address seen in one cycle is presented the next cycle.
   always @(posedge clk) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (rst && mem_wr) begin
         wl_a.push_back(mem_a);
         wl_d.push_back(mem_dout);
      end
      if (rst && if_ok) begin
         if_ok_cnt = if_ok_cnt + 1;
         gnt.push_back(1'b1);
      end
      if (rst && lsb_ok) gnt.push_back(1'b0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic stl();
      #1;
   endtask

   initial begin
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
      ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
      ram[32'h2000] = 8'hAB; ram[32'h2001] = 8'hCD;
      rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      lsb_req = 1'b0; lsb_we = 1'b0; lsb_width = 3'd4; lsb_addr = 32'h0; lsb_wdata = 32'h0;

      // Reset state
      repeat (2) nxt();
      stl();
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
      chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
      chk("rst_oks", {30'h0, if_ok, lsb_ok}, 32'h0);
      chk("rst_if_data", if_data, 32'h0);
      chk("rst_lsb_rdata", lsb_rdata, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b1;

      // Word fetch at 0x100
      nxt(); if_req = 1'b1; if_addr = 32'h100; stl();
      for (int i = 0; i < 4; i++) begin
         nxt(); stl();
         chk("fetch_addr", mem_a, 32'h100 + i);
      end
      nxt(); stl(); chk("fetch_ok_early", {31'h0, if_ok}, 32'h0);
      nxt(); stl();
      chk("fetch_ok", {31'h0, if_ok}, 32'h1);
      chk("fetch_data", if_data, 32'h00100513);
      if_req = 1'b0;
      nxt(); stl();
      chk("fetch_busy_after", {31'h0, busy}, 32'h0);
      chk("fetch_no_writes", wl_a.size(), 32'd0);

      // LSB and fetch together: 2-byte load first, fetch afterwards
      nxt();
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd2; lsb_addr = 32'h2000;
      if_req = 1'b1; if_addr = 32'h100; stl();
      nxt(); stl(); chk("arb_lsb_a0", mem_a, 32'h2000);
      nxt(); stl(); chk("arb_lsb_a1", mem_a, 32'h2001);
      nxt(); stl();
      nxt(); stl();
      chk("arb_lsb_ok", {31'h0, lsb_ok}, 32'h1);
      chk("arb_lsb_rdata", lsb_rdata, 32'h0000CDAB);
      chk("arb_if_not_ok", {31'h0, if_ok}, 32'h0);
      lsb_req = 1'b0;
      nxt(); stl(); chk("arb_idle", {31'h0, busy}, 32'h0);
      nxt(); stl(); chk("arb_fetch_a0", mem_a, 32'h100);
      repeat (5) nxt();
      stl();
      chk("arb_fetch_ok", {31'h0, if_ok}, 32'h1);
      chk("arb_fetch_data", if_data, 32'h00100513);
      if_req = 1'b0;

      // UART store held while the TX buffer is full
      nxt();
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd1; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
      io_buffer_full = 1'b1; wn = wl_a.size(); stl();
      for (int i = 0; i < 3; i++) begin
         nxt(); stl();
         chk("uart_held", {31'h0, mem_wr}, 32'h0);
      end
      nxt(); io_buffer_full = 1'b0; stl();
      chk("uart_wr", {31'h0, mem_wr}, 32'h1);
      chk("uart_a", mem_a, 32'h30000);
      chk("uart_dout", {24'h0, mem_dout}, 32'h41);
      nxt(); stl();
      chk("uart_ok", {31'h0, lsb_ok}, 32'h1);
      chk("uart_nwrites", wl_a.size() - wn, 32'd1);
      chk("uart_log", {wl_a[wn], 24'h0, wl_d[wn]} >> 32, 32'h30000);
      chk("uart_log_d", {24'h0, wl_d[wn]}, 32'h41);
      lsb_req = 1'b0;

      // Flush during a fetch, then a clean fetch at 0x200
      nxt(); if_req = 1'b1; if_addr = 32'h100; stl();
      nxt(); nxt();
      nxt(); flush = 1'b1; if_req = 1'b0; okc = if_ok_cnt; stl();
      chk("flush_busy_during", {31'h0, busy}, 32'h1);
      chk("flush_if_ok_gated", {31'h0, if_ok}, 32'h0);
      nxt(); flush = 1'b0; if_req = 1'b1; if_addr = 32'h200; stl();
      chk("flush_busy_after", {31'h0, busy}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         nxt(); stl();
         chk("refetch_addr", mem_a, 32'h200 + i);
      end
      nxt();
      nxt(); stl();
      chk("refetch_ok", {31'h0, if_ok}, 32'h1);
      chk("refetch_data", if_data, 32'h00100093);
      chk("flush_no_ok", if_ok_cnt, okc);
      if_req = 1'b0;

      // Flush in IDLE blocks the fetch for that cycle
      nxt(); if_req = 1'b1; if_addr = 32'h200; flush = 1'b1; stl();
      nxt(); flush = 1'b0; stl();
      chk("idle_flush_blocks", {31'h0, busy}, 32'h0);
      nxt(); stl();
      chk("idle_flush_then_go", {31'h0, busy}, 32'h1);
      repeat (5) nxt();
      stl();
      chk("idle_flush_fetch_ok", {31'h0, if_ok}, 32'h1);
      if_req = 1'b0;

      // rdy low for two cycles in a 4-byte store across 0x2000 (not UART space)
      nxt();
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd4; lsb_addr = 32'h1FFE; lsb_wdata = 32'hDDCCBBAA;
      io_buffer_full = 1'b1; wn = wl_a.size(); stl();
      nxt(); nxt();
      nxt(); rdy = 1'b0; stl(); chk("pause_wr0_a", {31'h0, mem_wr}, 32'h0);
      nxt(); stl(); chk("pause_wr0_b", {31'h0, mem_wr}, 32'h0);
      nxt(); rdy = 1'b1; stl(); chk("pause_resume_a", mem_a, 32'h2000);
      nxt(); nxt(); stl();
      chk("pause_store_ok", {31'h0, lsb_ok}, 32'h1);
      lsb_req = 1'b0; io_buffer_full = 1'b0;
      chk("pause_nwrites", wl_a.size() - wn, 32'd4);
      w = 32'hDDCCBBAA;
      for (int i = 0; i < 4; i++) begin
         chk("pause_log_a", wl_a[wn + i], 32'h1FFE + i);
         chk("pause_log_d", {24'h0, wl_d[wn + i]}, {24'h0, w[8*i +: 8]});
      end

      // rdy low for two cycles in a fetch
      nxt(); if_req = 1'b1; if_addr = 32'h100; stl();
      nxt(); nxt();
      nxt(); rdy = 1'b0;
      nxt();
      nxt(); rdy = 1'b1; stl();
      nxt(); nxt(); stl(); chk("pause_fetch_early", {31'h0, if_ok}, 32'h0);
      nxt(); stl();
      chk("pause_fetch_ok", {31'h0, if_ok}, 32'h1);
      chk("pause_fetch_data", if_data, 32'h00100513);
      if_req = 1'b0;

      // Width 3 is a 4-byte load
      nxt(); lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd3; lsb_addr = 32'h100; stl();
      repeat (5) nxt();
      stl(); chk("w3_ok_early", {31'h0, lsb_ok}, 32'h0);
      nxt(); stl();
      chk("w3_ok", {31'h0, lsb_ok}, 32'h1);
      chk("w3_rdata", lsb_rdata, 32'h00100513);
      lsb_req = 1'b0;

      // Width 0 store wraps past the top of the address space
      nxt();
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd0; lsb_addr = 32'hFFFFFFFE; lsb_wdata = 32'h44332211;
      wn = wl_a.size(); stl();
      repeat (5) nxt();
      stl();
      chk("wrap_ok", {31'h0, lsb_ok}, 32'h1);
      lsb_req = 1'b0;
      chk("wrap_nwrites", wl_a.size() - wn, 32'd4);
      w = 32'h44332211;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_log_a", wl_a[wn + i], 32'hFFFFFFFE + i);
         chk("wrap_log_d", {24'h0, wl_d[wn + i]}, {24'h0, w[8*i +: 8]});
      end

      // Both requesters held: grant order
      nxt();
      gnt.delete();
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd1; lsb_addr = 32'h2000;
      if_req = 1'b1; if_addr = 32'h100;
      repeat (45) nxt();
      lsb_req = 1'b0; if_req = 1'b0;
      for (int k = 0; k < 20 && busy; k++) nxt();
      stl();
      chk("grant_drain", {31'h0, busy}, 32'h0);
      chk("grant_count_ge9", {31'h0, gnt.size() >= 9}, 32'h1);
      for (int i = 0; i < 9; i++) begin
`ifdef MEM_SCHED_FAIR_EN
         chk("grant_order", {31'h0, gnt[i]}, (i == 4) ? 32'h1 : 32'h0);
`else
         chk("grant_order", {31'h0, gnt[i]}, 32'h0);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Byte-serial scheduler for the single 8-bit RAM/UART port, shared between instruction fetch (word reads) and the load/store buffer (1/2/4-byte reads and writes).
- Arbitrates, serialises multi-byte accesses little-endian, stalls UART writes on io_buffer_full, and aborts speculative reads on mispredict.
- Sits between the fetch/LSB blocks and the top-level mem_* pins.

Parameters:
- ADDR_W, 32, address width.
- STARVE_LIMIT, 4, consecutive LSB grants allowed while fetch is waiting (only used with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  pause: when low, all state is frozen and mem_wr is forced to 0.
- mem_din  in  8  RAM read data; valid the cycle after its address.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART TX full.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ok  out  1  one-cycle pulse; if_data is valid while it is high.
- if_data  out  32  fetched word.
- lsb_req  in  1  LSB request.
- lsb_we  in  1  1 = store.
- lsb_width  in  3  byte count.
- lsb_addr  in  ADDR_W  LSB address.
- lsb_wdata  in  32  store data.
- lsb_ok  out  1  one-cycle completion pulse.
- lsb_rdata  out  32  load data, zero-extended.
- flush  in  1  mispredict.
- busy  out  1  transaction in flight.

Behaviour:
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_ok=0, lsb_ok=0, if_data=0, lsb_rdata=0, busy=0, starvation counter=0.
- State machine: IDLE -> READ | WRITE -> DONE -> IDLE.
  - Requests are sampled only in IDLE.
  - Requesters hold req and operands stable until their ok, and drop req in the ok cycle.
  - DONE lasts exactly one cycle and asserts ok; no request is accepted in DONE.
- Arbitration: LSB has priority over fetch when both request in the same IDLE cycle.
- Width rules:
  - lsb_width of 1 or 2 is used as given; any other value is treated as 4.
  - Fetch is always 4 bytes.
  - Byte i uses address base+i, with modulo-2^ADDR_W wrap.
- READ of N bytes, request accepted at edge E0:
  - Cycle 1+i drives the address of byte i.
  - Cycle 2+i captures mem_din into bits [8i+7:8i].
  - Unused upper bytes are 0.
  - ok is high in cycle N+2 (word fetch: ok in cycle 6 after acceptance).
- WRITE of N bytes:
  - Cycle 1+i drives mem_a=base+i, mem_dout=wdata[8i+7:8i], mem_wr=1.
  - ok is high in cycle N+1.
- UART stall: if mem_a[17:16]==2'b11 and io_buffer_full=1 when a write byte is about to issue, that byte is held with mem_wr=0 until io_buffer_full=0. No reissue.
- Flush:
  - Any read in READ aborts immediately: state goes to IDLE next cycle, no ok, and partial data is discarded.
  - if_ok and read lsb_ok are forced to 0 in any cycle where flush=1.
  - Writes (committed stores only) are never aborted.
  - Flush in IDLE clears a pending fetch win: the fetch request is not accepted that cycle.
- rdy low mid-transaction: counters, addresses and captured bytes hold; the byte sequence resumes exactly where it stopped. The RAM read latency assumption is maintained by re-driving the same address.
- busy=1 from the acceptance edge through the DONE cycle.

Optional Feature:
- MEM_SCHED_FAIR_EN defined:
  - Count consecutive LSB grants taken while if_req=1.
  - When the count reaches STARVE_LIMIT, the next IDLE arbitration grants fetch.
  - The counter clears on any fetch grant.
- Undefined: strict LSB priority, no counter logic.

Decomposition:
- Shared package:
  - State encoding.
  - IO_ADDR_SEL (2'b11 on bits [17:16]).
  - Width decode constants.
  - ADDR_W default.
- One sub-module, mem_byte_sequencer: byte index counter, address increment, data shift/assemble, UART stall. The arbiter plus FSM stays in the parent.

Test Plan:
- Fetch only: if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0x100..0x103 in cycles 1-4; if_ok in cycle 6 with if_data=0x00100513.
- Simultaneous if_req and lsb_req (load, width 2, addr 0x2000, bytes 0xAB,0xCD) -> LSB served first, lsb_rdata=0x0000CDAB in cycle 4; fetch accepted in the following IDLE.
- Store to 0x30000, width 1, data 0x41, with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles; exactly one write of 0x41, then lsb_ok.
- Flush in cycle 3 of a fetch -> no if_ok; busy=0 the next cycle; a new if_req at 0x200 completes normally.
- rdy low for 2 cycles during a 4-byte store to 0x1FFE -> writes to 0x1FFE..0x2001 exactly once each, in order; mem_wr=0 while rdy low.
- MEM_SCHED_FAIR_EN, STARVE_LIMIT=4, lsb_req and if_req held continuously -> grant pattern LSB×4, IF, LSB×4, ...
